// File: rtl/i2c_arbiter_if.sv
// Arbiter bus: two requester channels plus the shared i2c_controller handshake.
// master = arbiter side, slave = requesters/controller side.
interface i2c_arbiter_if;
  logic        req_0;
  logic        req_1;
  logic [7:0]  dev_addr_0;
  logic [7:0]  dev_addr_1;
  logic [15:0] reg_data_0;
  logic [15:0] reg_data_1;
  logic        grant_0;
  logic        grant_1;
  logic        done_0;
  logic        done_1;
  logic        ack_ok_0;
  logic        ack_ok_1;
  logic        i2c_start;
  logic [7:0]  i2c_dev_addr;
  logic [15:0] i2c_reg_data;
  logic        i2c_ready;
  logic        i2c_ack;
  logic        busy;
  logic [2:0]  state_out;

  modport master (
    input  req_0, req_1, dev_addr_0, dev_addr_1, reg_data_0, reg_data_1,
    input  i2c_ready, i2c_ack,
    output grant_0, grant_1, done_0, done_1, ack_ok_0, ack_ok_1,
    output i2c_start, i2c_dev_addr, i2c_reg_data, busy, state_out
  );

  modport slave (
    output req_0, req_1, dev_addr_0, dev_addr_1, reg_data_0, reg_data_1,
    output i2c_ready, i2c_ack,
    input  grant_0, grant_1, done_0, done_1, ack_ok_0, ack_ok_1,
    input  i2c_start, i2c_dev_addr, i2c_reg_data, busy, state_out
  );
endinterface

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one i2c_controller between the init sequencer
// (requester 0) and the runtime writer (requester 1), with NACK retry and wait timeout.
//
// state     | meaning
// IDLE      | no owner; arbitrate when controller ready
// LAUNCH    | assert i2c_start for the granted transfer
// WAIT_BUSY | hold i2c_start until controller drops i2c_ready
// WAIT_DONE | wait for i2c_ready, then judge i2c_ack (retry on NACK)
// RESULT    | pulse done, publish ack_ok, release grant
module i2c_arbiter #(
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 255
) (
  input  logic          clk_in,
  input  logic          reset_not,
  i2c_arbiter_if.master bus
);

  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam int TMO_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
  localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    RESULT    = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           grant_q;
  logic [1:0]           ack_ok_q;
  logic                 last_grant;
  logic [RETRY_W-1:0]   retry_cnt;
  logic [TMO_W-1:0]     tmo_cnt;
  logic [7:0]           addr_q;
  logic [15:0]          data_q;

  logic take, win, retry_inc, tmo_clr, fin_ok, fin_fail, start_c, tmo_last;

  assign tmo_last = (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk_in or negedge reset_not) begin
    if (!reset_not) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      ack_ok_q   <= '0;
      last_grant <= 1'b1;
      retry_cnt  <= '0;
      tmo_cnt    <= '0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        grant_q       <= win ? 2'b10 : 2'b01;
        last_grant    <= win;
        addr_q        <= win ? bus.dev_addr_1 : bus.dev_addr_0;
        data_q        <= win ? bus.reg_data_1 : bus.reg_data_0;
        retry_cnt     <= '0;
        ack_ok_q[win] <= 1'b0;
      end else if (state_d == IDLE) begin
        grant_q <= '0;
      end
      if (retry_inc)
        retry_cnt <= retry_cnt + 1'b1;
      if (take || tmo_clr)
        tmo_cnt <= '0;
      else if (state_q == WAIT_BUSY || state_q == WAIT_DONE)
        tmo_cnt <= tmo_cnt + 1'b1;
      if (fin_ok || fin_fail)
        ack_ok_q[grant_q[1]] <= fin_ok;
    end
  end

  always_comb begin
    state_d   = state_q;
    take      = 1'b0;
    win       = 1'b0;
    retry_inc = 1'b0;
    tmo_clr   = 1'b0;
    fin_ok    = 1'b0;
    fin_fail  = 1'b0;
    start_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i2c_ready && (bus.req_0 || bus.req_1)) begin
          take    = 1'b1;
          win     = (bus.req_0 && bus.req_1) ? ~last_grant : bus.req_1;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        start_c = 1'b1;
        tmo_clr = 1'b1;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        start_c = 1'b1;
        if (!bus.i2c_ready) begin
          tmo_clr = 1'b1;
          state_d = WAIT_DONE;
        end else if (tmo_last) begin
          fin_fail = 1'b1;
          state_d  = RESULT;
        end
      end
      WAIT_DONE: begin
        if (bus.i2c_ready) begin
          if (bus.i2c_ack) begin
            fin_ok  = 1'b1;
            state_d = RESULT;
          end else if (retry_cnt < RETRY_MAX) begin
            retry_inc = 1'b1;
            state_d   = LAUNCH;
          end else begin
            fin_fail = 1'b1;
            state_d  = RESULT;
          end
        end else if (tmo_last) begin
          fin_fail = 1'b1;
          state_d  = RESULT;
        end
      end
      RESULT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // start and done decode straight from state so an async reset kills them at once
  assign bus.i2c_start    = start_c;
  assign bus.i2c_dev_addr = addr_q;
  assign bus.i2c_reg_data = data_q;
  assign bus.grant_0      = grant_q[0];
  assign bus.grant_1      = grant_q[1];
  assign bus.done_0       = (state_q == RESULT) && grant_q[0];
  assign bus.done_1       = (state_q == RESULT) && grant_q[1];
  assign bus.ack_ok_0     = ack_ok_q[0];
  assign bus.ack_ok_1     = ack_ok_q[1];
  assign bus.busy         = (state_q != IDLE);
  assign bus.state_out    = state_q;

endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed bench for i2c_arbiter with a small registered i2c_controller model.
module tb_i2c_arbiter;
  logic clk = 1'b0;
  logic reset_not = 1'b0;

  i2c_arbiter_if bus();

  i2c_arbiter #(.MAX_RETRY(3), .TIMEOUT(255)) dut (
    .clk_in   (clk),
    .reset_not(reset_not),
    .bus      (bus)
  );

  initial forever #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // controller model knobs
  int   busy_len  = 4;
  logic model_ack = 1'b1;
  logic hang      = 1'b0;
  logic hold_low  = 1'b0;

  // monitor results
  int         start_cnt   = 0;
  int         done0_cnt   = 0;
  int         done1_cnt   = 0;
  int         addr_glitch = 0;
  int         grant_who[$];
  logic [7:0] grant_addr[$];

  // controller: sees start mid-cycle, drops ready next cycle for busy_len cycles
  initial begin
    int   left;
    logic nr;
    left = 0;
    bus.i2c_ready = 1'b1;
    bus.i2c_ack   = 1'b0;
    forever begin
      @(negedge clk);
      nr = bus.i2c_ready;
      if (!reset_not) begin
        nr = 1'b1; left = 0;
      end else if (hold_low) begin
        nr = 1'b0; left = 0;
      end else if (bus.i2c_ready && bus.i2c_start && !hang) begin
        nr = 1'b0; left = busy_len - 1;
      end else if (!bus.i2c_ready) begin
        if (left == 0) nr = 1'b1;
        else left = left - 1;
      end
      @(posedge clk);
      #1;
      bus.i2c_ready = nr;
      bus.i2c_ack   = model_ack;
    end
  end

  initial begin
    logic ps, pg0, pg1, pact;
    logic [7:0]  pa;
    logic [15:0] pd;
    ps = 0; pg0 = 0; pg1 = 0; pact = 0; pa = 0; pd = 0;
    forever begin
      @(negedge clk);
      if (bus.i2c_start && !ps) start_cnt++;
      if (bus.done_0) done0_cnt++;
      if (bus.done_1) done1_cnt++;
      if (bus.grant_0 && !pg0) begin grant_who.push_back(0); grant_addr.push_back(bus.i2c_dev_addr); end
      if (bus.grant_1 && !pg1) begin grant_who.push_back(1); grant_addr.push_back(bus.i2c_dev_addr); end
      if (pact && bus.busy && (bus.i2c_dev_addr != pa || bus.i2c_reg_data != pd)) addr_glitch++;
      ps = bus.i2c_start; pg0 = bus.grant_0; pg1 = bus.grant_1;
      pa = bus.i2c_dev_addr; pd = bus.i2c_reg_data; pact = bus.busy;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no end of run, expected finish before 100000");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done(input string tag, input bit which, input int budget, output int waited);
    waited = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if ((which ? bus.done_1 : bus.done_0) === 1'b1) begin waited = i; break; end
    end
    n_cmp++;
    assert (waited != 0) else begin
      n_err++;
      $error("FAIL %s: observed no done, expected done within %0d cycles", tag, budget);
    end
  endtask

  task automatic wait_state(input string tag, input logic [2:0] st, input int budget);
    int seen;
    seen = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (bus.state_out === st) begin seen = i; break; end
    end
    n_cmp++;
    assert (seen != 0) else begin
      n_err++;
      $error("FAIL %s: observed state 0x%0h, expected state 0x%0h within %0d cycles", tag, bus.state_out, st, budget);
    end
  endtask

  initial begin
    int w, s0, d0, d1, q0, nd, hi, wb;
    bus.req_0 = 0; bus.req_1 = 0;
    bus.dev_addr_0 = 0; bus.dev_addr_1 = 0;
    bus.reg_data_0 = 0; bus.reg_data_1 = 0;

    // reset values
    ticks(3);
    check("rst_state",  32'(bus.state_out), 0);
    check("rst_busy",   32'(bus.busy), 0);
    check("rst_grant",  32'({bus.grant_1, bus.grant_0}), 0);
    check("rst_done",   32'({bus.done_1, bus.done_0}), 0);
    check("rst_ack_ok", 32'({bus.ack_ok_1, bus.ack_ok_0}), 0);
    check("rst_start",  32'(bus.i2c_start), 0);
    check("rst_addr",   32'(bus.i2c_dev_addr), 0);
    check("rst_data",   32'(bus.i2c_reg_data), 0);
    reset_not = 1'b1;
    ticks(2);

    // single requester, ACK on first try, 4 busy cycles: done at cycle 7
    s0 = start_cnt; d0 = done0_cnt;
    bus.dev_addr_0 = 8'h72; bus.reg_data_0 = 16'h9803; bus.req_0 = 1'b1;
    ticks(1);
    check("t1_c1_state", 32'(bus.state_out), 1);
    check("t1_c1_start", 32'(bus.i2c_start), 1);
    check("t1_c1_grant", 32'({bus.grant_1, bus.grant_0}), 'b01);
    check("t1_c1_addr",  32'(bus.i2c_dev_addr), 'h72);
    ticks(1);
    check("t1_c2_state", 32'(bus.state_out), 2);
    check("t1_c2_start", 32'(bus.i2c_start), 1);
    ticks(1);
    check("t1_c3_state", 32'(bus.state_out), 3);
    check("t1_c3_start", 32'(bus.i2c_start), 0);
    wait_done("t1_done", 1'b0, 20, w);
    check("t1_latency", 32'(w), 4);
    check("t1_ack_ok",  32'(bus.ack_ok_0), 1);
    check("t1_addr",    32'(bus.i2c_dev_addr), 'h72);
    check("t1_data",    32'(bus.i2c_reg_data), 'h9803);
    bus.req_0 = 1'b0;
    ticks(1);
    check("t1_done_width", 32'(bus.done_0), 0);
    check("t1_grant_drop", 32'(bus.grant_0), 0);
    check("t1_idle",       32'(bus.state_out), 0);
    check("t1_starts",     32'(start_cnt - s0), 1);
    check("t1_dones",      32'(done0_cnt - d0), 1);

    // both requesting after reset: 0,1,0,1
    reset_not = 1'b0;
    ticks(2);
    reset_not = 1'b1;
    busy_len = 2;
    bus.dev_addr_0 = 8'h10; bus.reg_data_0 = 16'h1111;
    bus.dev_addr_1 = 8'h20; bus.reg_data_1 = 16'h2222;
    ticks(1);
    q0 = grant_who.size();
    nd = 0;
    bus.req_0 = 1'b1; bus.req_1 = 1'b1;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (bus.done_0 || bus.done_1) nd++;
      if (nd == 4) begin bus.req_0 = 1'b0; bus.req_1 = 1'b0; break; end
    end
    check("rr_done_count", 32'(nd), 4);
    ticks(3);
    check("rr_grant_count", 32'(grant_who.size() - q0), 4);
    for (int k = 0; k < 4 && (q0 + k) < grant_who.size(); k++) begin
      check($sformatf("rr_order_%0d", k), 32'(grant_who[q0+k]), 32'(k % 2));
      check($sformatf("rr_addr_%0d", k), 32'(grant_addr[q0+k]), (k % 2) ? 'h20 : 'h10);
    end

    // NACK forever: 1 + 3 retries, then fail; held req_1 is re-granted
    busy_len = 1; model_ack = 1'b0;
    bus.dev_addr_1 = 8'h44; bus.reg_data_1 = 16'hABCD;
    s0 = start_cnt; d1 = done1_cnt;
    bus.req_1 = 1'b1;
    wait_done("nack_done", 1'b1, 100, w);
    check("nack_ack_ok", 32'(bus.ack_ok_1), 0);
    check("nack_addr",   32'(bus.i2c_dev_addr), 'h44);
    check("nack_data",   32'(bus.i2c_reg_data), 'hABCD);
    model_ack = 1'b1;
    ticks(1);
    check("nack_idle",   32'(bus.state_out), 0);
    check("nack_starts", 32'(start_cnt - s0), 4);
    check("nack_dones",  32'(done1_cnt - d1), 1);
    ticks(1);
    check("regrant_1", 32'(bus.grant_1), 1);
    wait_done("regrant_done", 1'b1, 40, w);
    bus.req_1 = 1'b0;
    check("regrant_ack_ok", 32'(bus.ack_ok_1), 1);

    // controller never goes busy: WAIT_BUSY lasts TIMEOUT cycles
    ticks(2);
    hang = 1'b1;
    s0 = start_cnt;
    bus.dev_addr_0 = 8'h55; bus.req_0 = 1'b1;
    hi = 0; wb = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.done_0) break;
      if (bus.i2c_start) hi++;
      if (bus.state_out == 3'd2) wb++;
    end
    check("tmo_done",      32'(bus.done_0), 1);
    check("tmo_start_hi",  32'(hi), 256);
    check("tmo_wait_busy", 32'(wb), 255);
    check("tmo_start_off", 32'(bus.i2c_start), 0);
    check("tmo_ack_ok",    32'(bus.ack_ok_0), 0);
    bus.req_0 = 1'b0; hang = 1'b0;
    ticks(1);
    check("tmo_starts", 32'(start_cnt - s0), 1);

    // reset during WAIT_DONE, held req_1 served after release
    ticks(2);
    busy_len = 10;
    bus.dev_addr_1 = 8'h66; bus.reg_data_1 = 16'h6606; bus.req_1 = 1'b1;
    wait_state("rst_wd_reach", 3'd3, 20);
    d1 = done1_cnt;
    reset_not = 1'b0;
    #1;
    check("rst_wd_start", 32'(bus.i2c_start), 0);
    check("rst_wd_grant", 32'({bus.grant_1, bus.grant_0}), 0);
    check("rst_wd_state", 32'(bus.state_out), 0);
    check("rst_wd_busy",  32'(bus.busy), 0);
    ticks(3);
    check("rst_wd_nodone", 32'(done1_cnt - d1), 0);
    reset_not = 1'b1;
    wait_done("rst_wd_resume", 1'b1, 40, w);
    bus.req_1 = 1'b0;
    check("rst_wd_ack_ok", 32'(bus.ack_ok_1), 1);
    check("rst_wd_addr",   32'(bus.i2c_dev_addr), 'h66);
    ticks(1);
    check("rst_wd_dones", 32'(done1_cnt - d1), 1);

    // req_1 dropped mid-transaction still completes once
    ticks(2);
    busy_len = 5;
    bus.dev_addr_1 = 8'h77; bus.req_1 = 1'b1;
    wait_state("drop_wd_reach", 3'd3, 20);
    bus.req_1 = 1'b0;
    d1 = done1_cnt;
    wait_done("drop_done", 1'b1, 30, w);
    ticks(4);
    check("drop_dones",  32'(done1_cnt - d1), 1);
    check("drop_grant",  32'(bus.grant_1), 0);
    check("drop_idle",   32'(bus.state_out), 0);
    check("drop_ack_ok", 32'(bus.ack_ok_1), 1);

    // controller not ready in IDLE blocks arbitration without losing the request
    hold_low = 1'b1;
    ticks(2);
    bus.dev_addr_0 = 8'h12; bus.req_0 = 1'b1;
    ticks(5);
    check("blk_state", 32'(bus.state_out), 0);
    check("blk_grant", 32'(bus.grant_0), 0);
    hold_low = 1'b0;
    wait_state("blk_launch", 3'd1, 6);
    check("blk_grant_late", 32'(bus.grant_0), 1);
    check("blk_addr",       32'(bus.i2c_dev_addr), 'h12);
    wait_done("blk_done", 1'b0, 30, w);
    bus.req_0 = 1'b0;
    check("blk_ack_ok", 32'(bus.ack_ok_0), 1);

    // reset in LAUNCH removes i2c_start without waiting for a clock
    ticks(2);
    bus.req_0 = 1'b1;
    wait_state("async_launch", 3'd1, 5);
    check("async_start_pre", 32'(bus.i2c_start), 1);
    reset_not = 1'b0;
    #1;
    check("async_start_post", 32'(bus.i2c_start), 0);
    check("async_grant_post", 32'(bus.grant_0), 0);
    bus.req_0 = 1'b0;
    ticks(2);
    reset_not = 1'b1;
    ticks(2);

    check("addr_stable", 32'(addr_glitch), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/i2c_arbiter.md
I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 Parameter: MAX_RETRY, default 3, NACK retries per transaction after the first attempt.
REQ-002 Parameter: TIMEOUT, default 255, maximum clk_in cycles spent in any single wait state.
REQ-003 clk_in  input  1  sole clock (I2C bit-rate clock); all logic on its rising edge.
REQ-004 reset_not  input  1  asynchronous, active-low reset.
REQ-005 req_0, req_1  input  1 each  requester transaction request, level; req_0 = init sequencer, req_1 = runtime writer.
REQ-006 dev_addr_0, dev_addr_1  input  8 each  target device address per requester.
REQ-007 reg_data_0, reg_data_1  input  16 each  {register, value} per requester.
REQ-008 grant_0, grant_1  output  1 each  high while that requester owns the controller.
REQ-009 done_0, done_1  output  1 each  one-cycle completion pulse.
REQ-010 ack_ok_0, ack_ok_1  output  1 each  result of last transaction, valid from done pulse until next grant.
REQ-011 i2c_start  output  1  start request to i2c_controller.
REQ-012 i2c_dev_addr  output  8; i2c_reg_data  output  16  latched address/data to controller.
REQ-013 i2c_ready  input  1  controller idle; i2c_ack  input  1  1 = slave acknowledged.
REQ-014 busy  output  1  high in every state except IDLE; state_out  output  3  current state encoding.

Function
REQ-015 States SHALL be IDLE=0, LAUNCH=1, WAIT_BUSY=2, WAIT_DONE=3, RESULT=4; other encodings go to IDLE next cycle.
REQ-016 IDLE: when i2c_ready=1 and any req high, grant SHALL be round-robin: single requester wins; both high -> requester not granted last time wins; next state LAUNCH.
REQ-017 On grant, the arbiter SHALL latch the winner's dev_addr/reg_data, clear retry_cnt and the timeout counter, and set the grant bit; the grant holds until RESULT exits.
REQ-018 LAUNCH: i2c_start SHALL be driven 1; next state WAIT_BUSY.
REQ-019 WAIT_BUSY: i2c_start SHALL stay 1 until i2c_ready sampled 0, then drop to 0 and go to WAIT_DONE; the timeout counter is cleared on entry.
REQ-020 WAIT_DONE: on i2c_ready=1 the arbiter SHALL sample i2c_ack; ack=1 -> RESULT with ack_ok=1; ack=0 and retry_cnt<MAX_RETRY -> retry_cnt+1, back to LAUNCH; ack=0 and retry_cnt=MAX_RETRY -> RESULT with ack_ok=0.
REQ-021 The timeout counter SHALL increment each cycle in WAIT_BUSY/WAIT_DONE; reaching TIMEOUT -> i2c_start=0, RESULT with ack_ok=0, no retry.
REQ-022 RESULT: done of the granted requester SHALL pulse exactly one cycle; grant drops and next state is IDLE; next arbitration is at the earliest one cycle later.
REQ-023 i2c_dev_addr/i2c_reg_data SHALL remain stable from LAUNCH through RESULT, including across retries.
REQ-024 Deasserting req mid-transaction SHALL NOT abort it; done still pulses.
REQ-025 A requester holding req after its done SHALL be re-granted only if the other req is low.
REQ-026 i2c_ready=0 in IDLE SHALL block arbitration; requests wait without loss.
REQ-027 Latency, uncontended, ACK first try: req high at cycle 0 -> i2c_start high from cycle 1, done at (controller busy cycles + 3).

Reset
REQ-028 reset_not=0 SHALL force state IDLE and set grant_*, done_*, ack_ok_*, i2c_start, busy, retry_cnt, timeout counter, i2c_dev_addr, i2c_reg_data to 0, and last-grant to requester 1 (so req_0 wins first tie).
REQ-029 Reset mid-transaction SHALL drop i2c_start immediately (asynchronous) with no done pulse; release resumes in IDLE.

Verification
REQ-030 req_0 only, dev 0x72, data 0x9803, model ACKs -> i2c_dev_addr=0x72, i2c_reg_data=0x9803, single start, done_0 pulse, ack_ok_0=1.
REQ-031 req_0 and req_1 high together after reset, both ACK -> order 0,1,0,1 while both held high; no back-to-back same grant.
REQ-032 Model NACKs always, MAX_RETRY=3 -> exactly 4 starts, then done pulse with ack_ok=0.
REQ-033 Model never drops i2c_ready after start, TIMEOUT=255 -> i2c_start released at 255 cycles, done pulse, ack_ok=0.
REQ-034 reset_not low during WAIT_DONE -> i2c_start=0, grants 0, no done; after release a held req_1 is served normally.
REQ-035 req_1 dropped during WAIT_DONE -> transaction completes, done_1 pulses once.
